// File: rtl/lockstep_ft_monitor.sv
// Lockstep fault-tolerance monitor: compares core A/B writebacks, checkpoints state, drives reset/recovery.
// Optional build macro FTM_ERROR_COUNT_EN adds a saturating error counter readable at word index 33.
module lockstep_ft_monitor #(
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_a_i,
  input  logic        we_b_i,
  input  logic [4:0]  addr_a_i,
  input  logic [4:0]  addr_b_i,
  input  logic [31:0] data_a_i,
  input  logic [31:0] data_b_i,
  input  logic [31:0] pc_i,
  input  logic        enable_i,
  input  logic        force_error_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        done_i,
  output logic        recover_o,
  output logic        reset_o,
  output logic        recovering_o,
  output logic        error_o
);

  typedef enum logic [1:0] {StIdle, StReset, StRecover} state_e;

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_e         state_q, state_d;
  logic [RCW-1:0] rstCnt_q, rstCnt_d;
  logic           error_q;
  logic           rvalid_q, rerr_q, rerr_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [31:0]    ckpt_q [32];
  logic [31:0]    ckptPc_q;
  logic [CNT_W-1:0] errCnt;
  logic           isIdle, mismatch, commit, gnt;
  logic [5:0]     wordIdx;
  logic           unusedBits;

  assign unusedBits = ^{data_be_i, data_wdata_i, data_addr_i[31:8], data_addr_i[1:0]};

  assign isIdle   = (state_q == StIdle);
  assign mismatch = isIdle & enable_i &
                    ((we_a_i != we_b_i) |
                     (we_a_i & we_b_i & ((addr_a_i != addr_b_i) | (data_a_i != data_b_i))) |
                     force_error_i);
  assign commit   = isIdle & ~mismatch & we_a_i & we_b_i & (addr_a_i != 5'd0);

  always_comb begin
    state_d  = state_q;
    rstCnt_d = rstCnt_q;
    case (state_q)
      StIdle: begin
        if (mismatch) begin
          state_d  = StReset;
          rstCnt_d = '0;
        end
      end
      StReset: begin
        if (rstCnt_q == RCW'(RESET_CYCLES - 1)) state_d = StRecover;
        else                                    rstCnt_d = rstCnt_q + 1'b1;
      end
      StRecover: begin
        if (done_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign reset_o      = (state_q == StReset);
  assign recover_o    = (state_q == StRecover);
  assign recovering_o = ~isIdle;
  assign error_o      = error_q;

  `ifdef FTM_ERROR_COUNT_EN
  localparam bit CntEn = 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       errCnt <= '0;
    else if (error_q && (errCnt != '1)) errCnt <= errCnt + 1'b1;
  end
  `else
  localparam bit CntEn = 1'b0;
  assign errCnt = '0;
  `endif

  // Recovery read map; entry 0 of the checkpoint is never written so x0 reads as zero.
  assign wordIdx = data_addr_i[7:2];
  assign gnt     = data_req_i & recovering_o;

  always_comb begin
    rdata_d = '0;
    rerr_d  = 1'b0;
    if (!data_we_i) begin
      if (wordIdx < 6'd32)                 rdata_d = ckpt_q[wordIdx[4:0]];
      else if (wordIdx == 6'd32)           rdata_d = ckptPc_q;
      else if (CntEn && wordIdx == 6'd33)  rdata_d = 32'(errCnt);
      else                                 rerr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rstCnt_q <= '0;
      error_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      ckptPc_q <= '0;
      for (int i = 0; i < 32; i++) ckpt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rstCnt_q <= rstCnt_d;
      error_q  <= mismatch;
      rvalid_q <= gnt;
      rdata_q  <= gnt ? rdata_d : '0;
      rerr_q   <= gnt & rerr_d;
      if (commit) begin
        ckpt_q[addr_a_i] <= data_a_i;
        ckptPc_q         <= pc_i;
      end
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = rerr_q;

endmodule

// File: tb/tb_lockstep_ft_monitor.sv
// Randomised self-checking bench for lockstep_ft_monitor against a cycle-level behavioural model.
module tb_lockstep_ft_monitor;
  localparam int RESET_CYCLES = 2;
`ifdef FTM_ERROR_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic clk, rst_n;
  logic weA, weB, enable, forceErr, req, dwe, done;
  logic [4:0] addrA, addrB;
  logic [31:0] dataA, dataB, pc, daddr, dwdata;
  logic [3:0] dbe;
  logic gnt, rvalid, derr, recover, resetO, recovering, errorO;
  logic [31:0] rdata;

  lockstep_ft_monitor #(.RESET_CYCLES(RESET_CYCLES), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .we_a_i(weA), .we_b_i(weB), .addr_a_i(addrA), .addr_b_i(addrB),
    .data_a_i(dataA), .data_b_i(dataB), .pc_i(pc),
    .enable_i(enable), .force_error_i(forceErr),
    .data_req_i(req), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(daddr),
    .data_wdata_i(dwdata), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
    .data_rdata_o(rdata), .data_err_o(derr), .done_i(done),
    .recover_o(recover), .reset_o(resetO), .recovering_o(recovering), .error_o(errorO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: architectural checkpoint plus remaining reset cycles and a recovery flag.
  logic [31:0] mRegs [32];
  logic [31:0] mPc;
  int          resetLeft;
  bit          mRecover, mError, mRv, mRvWrite, mErr;
  logic [31:0] mRdata;
  int          mCnt;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic bit modelBusy();
    return (resetLeft > 0) || mRecover;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
    mPc = '0; resetLeft = 0; mRecover = 0; mError = 0;
    mRv = 0; mRvWrite = 0; mErr = 0; mRdata = '0; mCnt = 0;
  endtask

  task automatic modelStep();
    bit idle, mism;
    int idx;
    idle = !modelBusy();
    mism = idle && enable && ((weA != weB) || (weA && weB && (addrA != addrB || dataA != dataB)) || forceErr);
    mRv = 0; mRvWrite = 0; mErr = 0; mRdata = '0;
    if (!idle && req) begin
      mRv = 1; mRvWrite = dwe;
      if (!dwe) begin
        idx = int'(daddr[7:2]);
        if (idx == 0)                    mRdata = 32'h0;
        else if (idx < 32)               mRdata = mRegs[idx];
        else if (idx == 32)              mRdata = mPc;
        else if (CntEn && idx == 33)     mRdata = 32'(mCnt);
        else                             mErr = 1;
      end
    end
    if (idle && !mism && weA && weB && addrA != 0) begin
      mRegs[addrA] = dataA;
      mPc = pc;
    end
    if (mError && mCnt < 65535) mCnt++;
    mError = mism;
    if (mism) resetLeft = RESET_CYCLES;
    else if (resetLeft > 0) begin
      resetLeft--;
      if (resetLeft == 0) mRecover = 1;
    end else if (mRecover && done) mRecover = 0;
  endtask

  task automatic checkAll();
    checkOutput("error_o", {31'b0, errorO}, {31'b0, mError});
    checkOutput("reset_o", {31'b0, resetO}, {31'b0, resetLeft > 0});
    checkOutput("recover_o", {31'b0, recover}, {31'b0, mRecover});
    checkOutput("recovering_o", {31'b0, recovering}, {31'b0, modelBusy()});
    checkOutput("rvalid", {31'b0, rvalid}, {31'b0, mRv});
    if (mRv) checkOutput("rerr", {31'b0, derr}, {31'b0, mErr});
    if (mRv && !mRvWrite) checkOutput("rdata", rdata, mRdata);
  endtask

  task automatic stepCycle();
    #1;
    checkOutput("gnt", {31'b0, gnt}, {31'b0, req && modelBusy()});
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic applyStimulus(input logic wa, input logic wb, input logic [4:0] aa, input logic [4:0] ab,
                               input logic [31:0] da, input logic [31:0] db, input logic [31:0] p,
                               input logic en, input logic fe, input logic rq, input logic w,
                               input logic [5:0] idx, input logic dn);
    weA = wa; weB = wb; addrA = aa; addrB = ab; dataA = da; dataB = db; pc = p;
    enable = en; forceErr = fe; req = rq; dwe = w; daddr = {24'h0, idx, 2'b00}; done = dn;
    dwdata = $urandom; dbe = 4'(($urandom));
    stepCycle();
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic readIdx(input logic [5:0] idx);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, idx, 0);
  endtask

  task automatic runToRecover();
    for (int i = 0; i < 10 && !mRecover; i++) applyIdle();
    if (!mRecover) checkOutput("recover_timeout", 0, 1);
  endtask

  task automatic finishRecovery();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    checkOutput("recover_drop", {31'b0, recover}, 0);
  endtask

  initial begin
    rst_n = 0;
    weA = 0; weB = 0; addrA = 0; addrB = 0; dataA = 0; dataB = 0; pc = 0;
    enable = 1; forceErr = 0; req = 0; dwe = 0; dbe = 0; daddr = 0; dwdata = 0; done = 0;
    modelReset();
    @(negedge clk); @(negedge clk);
    checkOutput("rst_recovering", {31'b0, recovering}, 0);
    checkOutput("rst_reset_o", {31'b0, resetO}, 0);
    checkOutput("rst_error_o", {31'b0, errorO}, 0);
    checkOutput("rst_rvalid", {31'b0, rvalid}, 0);
    rst_n = 1;

    applyStimulus(1, 1, 7, 7, 32'hAAAA, 32'hAAAA, 32'h7C, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5, 5, 32'h1234, 32'h1234, 32'h80, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 5, 0);
    checkOutput("idle_no_rvalid", {31'b0, rvalid}, 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("force_error_pulse", {31'b0, errorO}, 1);
    checkOutput("force_reset_o", {31'b0, resetO}, 1);
    runToRecover();
    readIdx(5);  checkOutput("rd_x5", rdata, 32'h1234); checkOutput("rd_x5_err", {31'b0, derr}, 0);
    readIdx(32); checkOutput("rd_pc", rdata, 32'h80);
    readIdx(0);  checkOutput("rd_x0", rdata, 0);
    readIdx(40); checkOutput("rd_40_err", {31'b0, derr}, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 5, 0);
    checkOutput("wr_err", {31'b0, derr}, 0);
    readIdx(5);  checkOutput("rd_x5_after_wr", rdata, 32'h1234);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("force_in_recover_ignored", {31'b0, errorO}, 0);
    finishRecovery();

    applyStimulus(1, 1, 7, 7, 32'h1, 32'h2, 32'h90, 1, 0, 0, 0, 0, 0);
    checkOutput("data_mismatch_pulse", {31'b0, errorO}, 1);
    runToRecover();
    readIdx(7);  checkOutput("rd_x7_unchanged", rdata, 32'hAAAA);
    finishRecovery();

    applyStimulus(1, 0, 3, 3, 32'h55, 32'h55, 32'hA0, 0, 0, 0, 0, 0, 0);
    checkOutput("we_mismatch_disabled", {31'b0, errorO}, 0);
    applyStimulus(1, 0, 3, 3, 32'h55, 32'h55, 32'hA4, 1, 0, 0, 0, 0, 0);
    checkOutput("we_mismatch_enabled", {31'b0, errorO}, 1);
    runToRecover();
    readIdx(33);
    if (CntEn) checkOutput("rd_err_count", rdata, 3);
    else       checkOutput("rd_33_err", {31'b0, derr}, 1);
    finishRecovery();

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    runToRecover();
    req = 1;
    #2 rst_n = 0;
    #1;
    checkOutput("async_recover_o", {31'b0, recover}, 0);
    checkOutput("async_recovering_o", {31'b0, recovering}, 0);
    checkOutput("async_gnt", {31'b0, gnt}, 0);
    checkOutput("async_reset_o", {31'b0, resetO}, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1;
    req = 0;

    for (int c = 0; c < 800; c++) begin
      logic wa, wb, en, fe;
      logic [4:0] aa, ab;
      logic [31:0] da, db;
      wa = 1'($urandom_range(0, 1)); wb = wa;
      aa = 5'($urandom); ab = aa;
      da = $urandom; db = da;
      en = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 39))
        0: wb = ~wa;
        1: if (wa) ab = aa ^ 5'($urandom_range(1, 31));
        2: if (wa) db = da ^ 32'(1 << $urandom_range(0, 31));
        default: ;
      endcase
      fe = en && ($urandom_range(0, 49) == 0);
      applyStimulus(wa, wb, aa, ab, da, db, $urandom, en, fe,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 9) == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32)),
                    ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
